ddr2_line_fetch: RTL
====================

Name: ddr2_line_fetch

Overview:
- Downstream consumer of the DDR2 core driver's read path.
- Requests one image line at a time by pulsing from_ddr2_strb, and captures the returned 24-bit words into a two-bank ping-pong line buffer.
- Replays the buffered line to the video timing side, one pixel per pix_de cycle.
- Decouples DDR2 read latency from display timing and flags underruns.

Parameters:
- HDATA_NUM, 4, words per line; must match the driver's HDATA_NUM; >= 2.
- VDATA_NUM, 64, lines per frame; must match the driver's VDATA_NUM; >= 2.
- DW, 24, pixel/data width.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- frame_start  in  1  one-cycle pulse at frame start (vsync); restarts fetching.
- pix_de  in  1  display data-enable; one pixel is consumed per asserted cycle.
- pix_data  out  DW  pixel output, registered.
- pix_valid  out  1  pix_data holds a buffered pixel this cycle.
- underrun  out  1  sticky: pix_de was asserted while the read bank was not full.
- line_cnt  out  10  lines fully captured in the current frame.
- frame_done  out  1  high once VDATA_NUM lines have been captured.
- from_ddr2_strb  out  1  one-cycle line request to the driver.
- from_ddr2_data  in  DW  read word from the driver.
- from_ddr2_data_valid  in  1  from_ddr2_data qualifier.

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - state=IDLE.
  - all outputs 0.
  - wr_bank=0, rd_bank=0, wr_ptr=0, rd_ptr=0, full[1:0]=0.
- Storage is 2 x HDATA_NUM x DW registers or inferred RAM, with one write port and one read port.
- Fill FSM states: IDLE, REQ, FILL, WAIT.
  - IDLE: frame_start -> REQ. Valid words arriving in IDLE are discarded.
  - REQ: drive from_ddr2_strb=1 for exactly one cycle, then go to FILL.
  - FILL: each from_ddr2_data_valid writes mem[wr_bank][wr_ptr] and increments wr_ptr.
  - On the valid with wr_ptr==HDATA_NUM-1, all of the following happen in the same edge:
    - full[wr_bank] is set.
    - wr_bank toggles.
    - wr_ptr is cleared to 0.
    - line_cnt increments.
    - Next state:
      - if line_cnt==VDATA_NUM-1: frame_done=1 and go to IDLE;
      - else if full[~wr_bank]==0 (evaluated after any same-cycle read release): go to REQ;
      - else go to WAIT.
  - WAIT: go to REQ when full[wr_bank] clears. Valid words arriving in WAIT are discarded.
- Request spacing: successive from_ddr2_strb pulses are at least 2 cycles apart, so the driver has returned to IDLE before the next request.
- Read side:
  - pix_de=1 and full[rd_bank]=1: next cycle pix_data=mem[rd_bank][rd_ptr] and pix_valid=1 (latency 1). rd_ptr increments.
  - On rd_ptr==HDATA_NUM-1 in that same edge: full[rd_bank] clears, rd_bank toggles, rd_ptr is cleared to 0.
  - pix_de=1 and full[rd_bank]=0: underrun is set, pix_valid=0, pix_data holds its last value, pointers are unchanged.
  - pix_de=0: pix_valid=0, pix_data holds.
- Simultaneous fill-complete and read-release on different banks: both take effect in the same edge. The fill side sees the released bank as empty and goes directly to REQ.
- A fill and a read never target the same bank; the full flags guarantee this.
- frame_start in any state, including mid-line (this is an abort):
  - clears full, both pointers, both bank selects, line_cnt, frame_done and underrun;
  - sets state=REQ;
  - pix_valid=0 that cycle;
  - takes priority over same-cycle pix_de and data_valid.
  - Any words still returning from an aborted request are written into the new line. Frame_start must be issued only while the driver is idle; the integration owner guarantees this.
- line_cnt saturates at VDATA_NUM; it does not wrap.

Decomposition:
- Shared package ddr2_vid_pkg holds:
  - fill FSM state encodings IDLE/REQ/FILL/WAIT;
  - shared defaults HDATA_NUM_DEF, VDATA_NUM_DEF, DW_DEF, also used by ddr2_core_driver wrappers.
- One sub-module: ddr2_pingpong_ram (2*HDATA_NUM x DW, sync write, sync read, bank+ptr addressing).
- Control logic stays in ddr2_line_fetch.

Test Plan (HDATA_NUM=4, VDATA_NUM=3):
- Basic fetch:
  - Stimulus: reset; frame_start; driver model returns 4 valids of 0xA00000..0xA00003 three cycles after each strb; pix_de is 0.
  - Required: strb once; line_cnt=1; second strb pulses immediately; third strb only after a read release.
- Replay:
  - Stimulus: after two lines are captured, assert pix_de for 4 cycles.
  - Required: pix_data=0xA00000..0xA00003 with pix_valid, each 1 cycle after its pix_de; bank released; a new strb within 2 cycles.
- Underrun:
  - Stimulus: frame_start, then pix_de=1 before any data returns.
  - Required: underrun=1, pix_valid=0; underrun stays 1 until the next frame_start.
- Frame end:
  - Stimulus: capture 3 lines with continuous pix_de reads.
  - Required: frame_done=1, line_cnt=3, state IDLE, no further strb; stray valids ignored.
- Simultaneous events:
  - Stimulus: the 4th valid of a line and the last pix_de of the other bank in the same cycle.
  - Required: both flags update; FSM goes to REQ, not WAIT.
- Abort:
  - Stimulus: frame_start after 2 of 4 words captured.
  - Required: full=0, underrun=0, line_cnt=0; strb one cycle later; rst mid-line returns all outputs to 0.

Source files
------------

// File: rtl/ddr2_vid_pkg.sv
// Shared definitions for the DDR2 video read path: line-fetch FSM encodings and
// geometry defaults also used by the ddr2_core_driver wrappers.
package ddr2_vid_pkg;

    localparam int HDATA_NUM_DEF = 4;
    localparam int VDATA_NUM_DEF = 64;
    localparam int DW_DEF        = 24;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] FILL = 2'd2;
    localparam logic [1:0] WAIT = 2'd3;

endpackage

// File: rtl/ddr2_pingpong_ram.sv
// Two-bank line buffer: one synchronous write port, one synchronous read port,
// each addressed by bank select plus word pointer.
module ddr2_pingpong_ram
    import ddr2_vid_pkg::*;
#(
    parameter int HDATA_NUM = HDATA_NUM_DEF,
    parameter int DW        = DW_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic                         wr_bank,
    input  logic [$clog2(HDATA_NUM)-1:0] wr_ptr,
    input  logic [DW-1:0]                wr_data,
    input  logic                         rd_en,
    input  logic                         rd_bank,
    input  logic [$clog2(HDATA_NUM)-1:0] rd_ptr,
    output logic [DW-1:0]                rd_data
);

    localparam int AW = $clog2(2 * HDATA_NUM);

    logic [DW-1:0] mem [2*HDATA_NUM];
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;

    assign wr_addr = (wr_bank ? AW'(HDATA_NUM) : AW'(0)) + AW'(wr_ptr);
    assign rd_addr = (rd_bank ? AW'(HDATA_NUM) : AW'(0)) + AW'(rd_ptr);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register holds its value when no pixel is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ddr2_line_fetch.sv
// Fetches image lines from the DDR2 driver into a ping-pong buffer and replays
// them to the display side one pixel per pix_de cycle, flagging underruns.
module ddr2_line_fetch
    import ddr2_vid_pkg::*;
#(
    parameter int HDATA_NUM = HDATA_NUM_DEF,
    parameter int VDATA_NUM = VDATA_NUM_DEF,
    parameter int DW        = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic          pix_de,
    output logic [DW-1:0] pix_data,
    output logic          pix_valid,
    output logic          underrun,
    output logic [9:0]    line_cnt,
    output logic          frame_done,
    output logic          from_ddr2_strb,
    input  logic [DW-1:0] from_ddr2_data,
    input  logic          from_ddr2_data_valid
);

    localparam int             PW        = $clog2(HDATA_NUM);
    localparam logic [PW-1:0]  PTR_LAST  = PW'(HDATA_NUM - 1);
    localparam logic [9:0]     LINE_LAST = 10'(VDATA_NUM - 1);
    localparam logic [9:0]     LINE_MAX  = 10'(VDATA_NUM);

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v >= LINE_MAX) ? v : v + 10'd1;
    endfunction

    logic [1:0]    state;
    logic          wr_bank;
    logic          rd_bank;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [1:0]    full;
    logic          vld_p1;

    logic          rd_fire;
    logic          rd_release;
    logic          wr_fire;
    logic          wr_last;
    logic [1:0]    rel_mask;
    logic [1:0]    full_rel;
    logic [1:0]    full_nxt;

    // frame_start overrides both the read and the write side in its cycle.
    assign rd_fire    = pix_de && full[rd_bank] && !frame_start;
    assign rd_release = rd_fire && (rd_ptr == PTR_LAST);
    assign wr_fire    = (state == FILL) && from_ddr2_data_valid && !frame_start;
    assign wr_last    = wr_fire && (wr_ptr == PTR_LAST);

    // Fill decisions see a bank released in the same cycle as already empty.
    assign rel_mask = rd_release ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;
    assign full_rel = full & ~rel_mask;

    always_comb begin
        full_nxt = full_rel;
        if (wr_last) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    assign from_ddr2_strb = (state == REQ);
    assign pix_valid      = vld_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            full       <= 2'b00;
            vld_p1     <= 1'b0;
            underrun   <= 1'b0;
            line_cnt   <= '0;
            frame_done <= 1'b0;
        end else if (frame_start) begin
            state      <= REQ;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            full       <= 2'b00;
            vld_p1     <= 1'b0;
            underrun   <= 1'b0;
            line_cnt   <= '0;
            frame_done <= 1'b0;
        end else begin
            // stage p0 -> p1: buffered pixel read
            vld_p1 <= rd_fire;
            full   <= full_nxt;
            if (pix_de && !full[rd_bank]) begin
                underrun <= 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
                if (rd_ptr == PTR_LAST) begin
                    rd_bank <= ~rd_bank;
                end
            end

            case (state)
                REQ: state <= FILL;
                FILL: begin
                    if (wr_fire) begin
                        wr_ptr <= wr_last ? '0 : wr_ptr + PW'(1);
                    end
                    if (wr_last) begin
                        wr_bank  <= ~wr_bank;
                        line_cnt <= sat_inc(line_cnt);
                        if (line_cnt == LINE_LAST) begin
                            frame_done <= 1'b1;
                            state      <= IDLE;
                        end else if (!full_rel[~wr_bank]) begin
                            state <= REQ;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!full_rel[wr_bank]) begin
                        state <= REQ;
                    end
                end
                default: state <= state;
            endcase
        end
    end

    ddr2_pingpong_ram #(
        .HDATA_NUM (HDATA_NUM),
        .DW        (DW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_fire),
        .wr_bank (wr_bank),
        .wr_ptr  (wr_ptr),
        .wr_data (from_ddr2_data),
        .rd_en   (rd_fire),
        .rd_bank (rd_bank),
        .rd_ptr  (rd_ptr),
        .rd_data (pix_data)
    );

endmodule
